// File: rtl/soc_ram_ctrl_pkg.sv
// soc_ram_ctrl_pkg: shared types and constants for the AHB-Lite SRAM controller.
//   state_e  - controller FSM states (3-bit encoding)
//   HTRANS_* - AHB transfer types
//   HSIZE_*  - AHB transfer sizes used by the controller
//   HRESP_*  - AHB response codes
package soc_ram_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD      = 3'd1,
    ST_RD_DONE = 3'd2,
    ST_WR      = 3'd3,
    ST_RMW_RD  = 3'd4,
    ST_RMW_WR  = 3'd5,
    ST_ERR1    = 3'd6,
    ST_ERR2    = 3'd7
  } state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/soc_ram_byte_merge.sv
// soc_ram_byte_merge: replaces the byte lanes addressed by a sub-word write
// inside the word read back from the RAM.
//   old_word_i  - word currently stored in the RAM
//   new_word_i  - write data, little-endian lanes
//   size_i      - HSIZE of the write (byte / half / word)
//   addr_lo_i   - byte address bits [1:0]
//   merged_o    - word to write back
module soc_ram_byte_merge
  import soc_ram_ctrl_pkg::*;
(
  input  logic [31:0] old_word_i,
  input  logic [31:0] new_word_i,
  input  logic [2:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  output logic [31:0] merged_o
);

  logic [3:0] mask;

  always_comb begin
    case (size_i)
      HSIZE_BYTE: mask = 4'b0001 << addr_lo_i;
      HSIZE_HALF: mask = addr_lo_i[1] ? 4'b1100 : 4'b0011;
      default:    mask = 4'b1111;
    endcase
    merged_o = old_word_i;
    for (int i = 0; i < 4; i++)
      if (mask[i]) merged_o[8*i +: 8] = new_word_i[8*i +: 8];
  end

endmodule

// File: rtl/soc_ram_ahb_ctrl.sv
// soc_ram_ahb_ctrl: AHB-Lite slave in front of a single-port, one-cycle-read
// latency SRAM without byte enables.
//   Clock/reset : pll_core_cpuclk, pad_cpu_rst_b (async, active-low)
//   AHB slave   : hsel, haddr, htrans, hwrite, hsize, hwdata, hready ->
//                 hreadyout, hresp, hrdata
//   RAM port    : ram_addr, ram_wdata, ram_we -> ram_rdata (registered,
//                 valid the cycle after a ram_we=0 cycle)
// Macro SOC_RAM_CTRL_RMW_EN: when defined, byte/half writes are done as a
// read-modify-write (one wait state); when undefined they get ERROR.
module soc_ram_ahb_ctrl
  import soc_ram_ctrl_pkg::*;
#(
  parameter int ADDRWIDTH = 16
) (
  input  logic                 pll_core_cpuclk,
  input  logic                 pad_cpu_rst_b,
  input  logic                 hsel,
  input  logic [31:0]          haddr,
  input  logic [1:0]           htrans,
  input  logic                 hwrite,
  input  logic [2:0]           hsize,
  input  logic [31:0]          hwdata,
  input  logic                 hready,
  output logic                 hreadyout,
  output logic                 hresp,
  output logic [31:0]          hrdata,
  output logic [ADDRWIDTH-1:0] ram_addr,
  output logic [31:0]          ram_wdata,
  output logic                 ram_we,
  input  logic [31:0]          ram_rdata
);

  state_e               state_q, state_d;
  logic [ADDRWIDTH-1:0] addr_q;
  logic                 open_slot, accept, illegal;

  // Address bits above the RAM depth alias onto the same words.
  logic unused_haddr_hi;
  assign unused_haddr_hi = ^haddr[31:ADDRWIDTH+2];

`ifdef SOC_RAM_CTRL_RMW_EN
  logic [2:0]  size_q;
  logic [1:0]  lo_q;
  logic [31:0] wdata_q;
  logic [31:0] merged;

  soc_ram_byte_merge u_merge (
    .old_word_i (ram_rdata),
    .new_word_i (wdata_q),
    .size_i     (size_q),
    .addr_lo_i  (lo_q),
    .merged_o   (merged)
  );
`endif

  // Next state. Only cycles that end the previous data phase with
  // hreadyout=1 take a new address phase; ERR2 deliberately drops it.
  always_comb begin
    open_slot = (state_q == ST_IDLE) || (state_q == ST_RD_DONE) ||
                (state_q == ST_WR)   || (state_q == ST_RMW_WR);
    accept    = open_slot && hsel && hready &&
                ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));
    illegal   = (hsize > HSIZE_WORD) ||
                ((hsize == HSIZE_HALF) && haddr[0]) ||
                ((hsize == HSIZE_WORD) && (haddr[1:0] != 2'b00));
`ifndef SOC_RAM_CTRL_RMW_EN
    illegal   = illegal || (hwrite && (hsize != HSIZE_WORD));
`endif
    state_d = ST_IDLE;
    case (state_q)
      ST_RD:     state_d = ST_RD_DONE;
      ST_ERR1:   state_d = ST_ERR2;
`ifdef SOC_RAM_CTRL_RMW_EN
      ST_RMW_RD: state_d = ST_RMW_WR;
`endif
      default: begin
        if (accept) begin
          if (illegal)                  state_d = ST_ERR1;
          else if (!hwrite)             state_d = ST_RD;
          else if (hsize == HSIZE_WORD) state_d = ST_WR;
          else                          state_d = ST_RMW_RD;
        end
      end
    endcase
  end

  always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
`ifdef SOC_RAM_CTRL_RMW_EN
      size_q  <= '0;
      lo_q    <= '0;
      wdata_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q <= haddr[ADDRWIDTH+1:2];
`ifdef SOC_RAM_CTRL_RMW_EN
        size_q <= hsize;
        lo_q   <= haddr[1:0];
`endif
      end
`ifdef SOC_RAM_CTRL_RMW_EN
      // hwdata belongs to this data phase; hold it for the write-back cycle.
      if (state_q == ST_RMW_RD) wdata_q <= hwdata;
`endif
    end
  end

  // Bus and RAM outputs decode straight from the state register, so reset
  // alone drives every output to its idle value.
  always_comb begin
    hreadyout = 1'b1;
    hresp     = HRESP_OKAY;
    hrdata    = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    ram_we    = 1'b0;
    case (state_q)
      ST_RD: begin
        ram_addr  = addr_q;
        hreadyout = 1'b0;
      end
      ST_RD_DONE: hrdata = ram_rdata;
      ST_WR: begin
        ram_addr  = addr_q;
        ram_we    = 1'b1;
        ram_wdata = hwdata;
      end
`ifdef SOC_RAM_CTRL_RMW_EN
      ST_RMW_RD: begin
        ram_addr  = addr_q;
        hreadyout = 1'b0;
      end
      ST_RMW_WR: begin
        ram_addr  = addr_q;
        ram_we    = 1'b1;
        ram_wdata = merged;
      end
`endif
      ST_ERR1: begin
        hresp     = HRESP_ERROR;
        hreadyout = 1'b0;
      end
      ST_ERR2: hresp = HRESP_ERROR;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_soc_ram_ahb_ctrl.sv
// tb_soc_ram_ahb_ctrl: self-checking bench for soc_ram_ahb_ctrl. Holds a
// model of the external SRAM plus a word-array reference of its intended
// contents; expected responses come from the AHB rules applied to that array.
module tb_soc_ram_ahb_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hsel, hwrite, hready;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic        hreadyout, hresp;
  logic [31:0] hrdata;
  logic [15:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_we;
  bit   [31:0] ram_rdata;

  bit [31:0] ram     [0:65535];
  bit [31:0] ref_mem [0:65535];

  int total = 0;
  int bad   = 0;

`ifdef SOC_RAM_CTRL_RMW_EN
  localparam bit RMW = 1'b1;
`else
  localparam bit RMW = 1'b0;
`endif

  always #5 clk = ~clk;

  // Single slave on the bus: hready is the slave's own hreadyout.
  assign hready = hreadyout;

  soc_ram_ahb_ctrl #(.ADDRWIDTH(16)) dut (
    .pll_core_cpuclk (clk),
    .pad_cpu_rst_b   (rst_n),
    .hsel            (hsel),
    .haddr           (haddr),
    .htrans          (htrans),
    .hwrite          (hwrite),
    .hsize           (hsize),
    .hwdata          (hwdata),
    .hready          (hready),
    .hreadyout       (hreadyout),
    .hresp           (hresp),
    .hrdata          (hrdata),
    .ram_addr        (ram_addr),
    .ram_wdata       (ram_wdata),
    .ram_we          (ram_we),
    .ram_rdata       (ram_rdata)
  );

  // External single-port SRAM: write when we=1, else registered read.
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
    else        ram_rdata     <= ram[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // One non-pipelined transfer; entered and left at a negedge with the bus idle.
  task automatic xfer(input bit wr, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, output logic [31:0] rd, output int waits,
                      output logic r_first, output logic r_last, output bit tmo);
    hsel = 1'b1; htrans = 2'b10; haddr = a; hwrite = wr; hsize = sz;
    @(posedge clk); @(negedge clk);
    hsel = 1'b0; htrans = 2'b00; hwdata = wd;
    waits = 0; r_first = hresp; r_last = 1'b0; rd = '0; tmo = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (hreadyout) begin
        rd = hrdata; r_last = hresp; tmo = 1'b0;
        break;
      end
      waits++;
      @(posedge clk); @(negedge clk);
    end
    @(posedge clk); @(negedge clk);
  endtask

  // Transfer plus expectations derived from the AHB rules and ref_mem.
  task automatic do_op(input bit wr, input logic [31:0] a, input logic [2:0] sz,
                       input logic [31:0] wd, input string tag);
    int w, lo, nb, waits, exp_waits;
    bit legal, tmo;
    logic [31:0] rd, exp_rd;
    logic rf, rl;
    w  = int'((a >> 2) & 32'hFFFF);
    lo = int'(a % 4);
    nb = (sz <= 3'd2) ? (1 << sz) : 4;
    legal = (sz <= 3'd2) && ((lo % nb) == 0) && (RMW || !wr || sz == 3'd2);
    exp_waits = (!legal) ? 1 : (wr && sz == 3'd2) ? 0 : 1;
    exp_rd = (legal && !wr) ? ref_mem[w] : 32'h0;
    xfer(wr, a, sz, wd, rd, waits, rf, rl, tmo);
    if (legal && wr)
      for (int b = 0; b < 4; b++)
        if (b >= lo && b < lo + nb) ref_mem[w][8*b +: 8] = wd[8*b +: 8];
    chk({tag, "_timeout"}, {31'b0, tmo}, 32'd0);
    chk({tag, "_waits"},   waits, exp_waits);
    chk({tag, "_resp1"},   {31'b0, rf}, {31'b0, !legal});
    chk({tag, "_resp2"},   {31'b0, rl}, {31'b0, !legal});
    chk({tag, "_rdata"},   rd, exp_rd);
    chk({tag, "_ram"},     ram[w], ref_mem[w]);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_hreadyout"}, {31'b0, hreadyout}, 32'd1);
    chk({tag, "_hresp"},     {31'b0, hresp},     32'd0);
    chk({tag, "_hrdata"},    hrdata,             32'd0);
    chk({tag, "_ram_we"},    {31'b0, ram_we},    32'd0);
    chk({tag, "_ram_addr"},  {16'b0, ram_addr},  32'd0);
    chk({tag, "_ram_wdata"}, ram_wdata,          32'd0);
  endtask

  initial begin
    rst_n = 1'b0; hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
    hsize = 3'd0; hwdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("por");
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);

    // Word write then read.
    do_op(1'b1, 32'h10, 3'd2, 32'hDEADBEEF, "w10");
    do_op(1'b0, 32'h10, 3'd2, 32'h0,        "r10");
    // Byte write into a known word.
    do_op(1'b1, 32'h20, 3'd2, 32'h11223344, "w20");
    do_op(1'b1, 32'h22, 3'd0, 32'h00AA0000, "b22");
    do_op(1'b0, 32'h20, 3'd2, 32'h0,        "r20");
    // Half writes, aligned and misaligned.
    do_op(1'b1, 32'h24, 3'd2, 32'h11223344, "w24");
    do_op(1'b1, 32'h26, 3'd1, 32'hBEEF0000, "h26");
    do_op(1'b0, 32'h24, 3'd2, 32'h0,        "r24a");
    do_op(1'b1, 32'h25, 3'd1, 32'h12345678, "h25");
    do_op(1'b0, 32'h24, 3'd2, 32'h0,        "r24b");
    // Sub-word read returns the whole word; illegal sizes/alignments error.
    do_op(1'b1, 32'h28, 3'd2, 32'h11223344, "w28");
    do_op(1'b0, 32'h29, 3'd0, 32'h0,        "rb29");
    do_op(1'b0, 32'h2A, 3'd1, 32'h0,        "rh2a");
    do_op(1'b0, 32'h2A, 3'd2, 32'h0,        "rw2a");
    do_op(1'b1, 32'h28, 3'd3, 32'hFFFFFFFF, "sz3");

    // Pipelined word write immediately followed by a read of the same word.
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h30; hwrite = 1'b1; hsize = 3'd2;
    @(posedge clk); @(negedge clk);
    hwdata = 32'hA5A55A5A; hwrite = 1'b0;
    chk("b2b_wr_ready", {31'b0, hreadyout}, 32'd1);
    ref_mem[12] = 32'hA5A55A5A;
    @(posedge clk); @(negedge clk);
    hsel = 1'b0; htrans = 2'b00;
    chk("b2b_rd_wait", {31'b0, hreadyout}, 32'd0);
    @(posedge clk); @(negedge clk);
    chk("b2b_rd_ready", {31'b0, hreadyout}, 32'd1);
    chk("b2b_rd_data",  hrdata, ref_mem[12]);
    @(posedge clk); @(negedge clk);

    // Reset in the middle of a byte write's first data-phase cycle.
    do_op(1'b1, 32'h40, 3'd2, 32'hCAFEF00D, "w40");
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h40; hwrite = 1'b1; hsize = 3'd0;
    @(posedge clk); @(negedge clk);
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'h55555555;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("midrst_ram", ram[16], ref_mem[16]);
    do_op(1'b0, 32'h40, 3'd2, 32'h0, "r40");

    // Random traffic over 16 words, with aliasing upper address bits.
    for (int n = 0; n < 150; n++) begin
      int w, lo;
      bit wr;
      logic [2:0] sz;
      logic [31:0] a;
      w  = $urandom_range(0, 15);
      lo = $urandom_range(0, 3);
      sz = 3'($urandom_range(0, 3));
      wr = 1'($urandom_range(0, 1));
      a  = ($urandom & 32'hFFFC_0000) | (w << 2) | lo;
      do_op(wr, a, sz, $urandom, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/soc_ram_ahb_ctrl.md
# soc_ram_ahb_ctrl

AHB-Lite slave controller sitting directly upstream of the single-port FPGA SRAM (`soc_fpga_ram`) in the smart_run SoC. It converts AHB-Lite transfers into that RAM's one-port, one-cycle-read-latency protocol, in which a read is performed only when write-enable is low. The RAM has no byte enables, so sub-word writes are performed as read-modify-write. It also inserts the wait states and ERROR responses the bus requires.

## Interface
- ADDRWIDTH, 16: RAM word-address width; RAM depth = 2**ADDRWIDTH words of 32 bits.
- pll_core_cpuclk  in  1  sole clock; all state on the rising edge.
- pad_cpu_rst_b  in  1  reset, asynchronous assert, active-low.
- hsel  in  1  slave select.
- haddr  in  32  byte address; bits [ADDRWIDTH+1:2] select the word; higher bits are ignored (aliasing).
- htrans  in  2  transfer type.
- hwrite  in  1  1 = write.
- hsize  in  3  0 = byte, 1 = half, 2 = word; any other value is illegal.
- hwdata  in  32  write data, little-endian lanes.
- hready  in  1  bus ready.
- hreadyout  out  1  slave ready.
- hresp  out  1  0 = OKAY, 1 = ERROR.
- hrdata  out  32  read data.
- ram_addr  out  ADDRWIDTH  RAM address.
- ram_wdata  out  32  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_rdata  in  32  RAM registered read data, valid one cycle after a cycle with ram_we=0.

## Operation
- Address phase accepted when hsel & hready & htrans[1]. On acceptance, latch addr, hwrite and hsize. IDLE/BUSY or unselected transfers get a zero-wait OKAY.
- A transfer is illegal if hsize>2, if a half is misaligned (haddr[0]), or if a word is misaligned (haddr[1:0]≠0).
- FSM states are IDLE, RD, RD_DONE, WR, RMW_RD, RMW_WR, ERR1, ERR2. Next state is chosen from the accepted transfer: illegal→ERR1; read→RD; word write→WR; sub-word write→RMW_RD. With nothing accepted, next state is IDLE.
- IDLE: hreadyout=1; ram_we=0; ram_addr/ram_wdata = 0.
- RD: ram_addr=latched word address; ram_we=0; hreadyout=0. Always goes to RD_DONE.
- RD_DONE: hrdata=ram_rdata; hreadyout=1. The full word is returned and the master selects the lanes.
- WR: ram_we=1; ram_wdata=hwdata; hreadyout=1.
- RMW_RD: captures hwdata into wdata_q; issues the RAM read; hreadyout=0. Always goes to RMW_WR.
- RMW_WR: ram_we=1; ram_wdata = ram_rdata with the selected lanes replaced from wdata_q; hreadyout=1.
- Lane select: byte uses addr[1:0]; half uses addr[1] (lanes 1:0 or 3:2).
- ERR1: hresp=1, hreadyout=0; no RAM access. Always goes to ERR2.
- ERR2: hresp=1, hreadyout=1. Any address phase presented here is ignored (dropped) and next state is IDLE.
- States with hreadyout=1 (RD_DONE, WR, RMW_WR) also accept the next address phase and pick the next state from it.
- hrdata = 0 outside RD_DONE.
- Reset (any cycle, including mid-RMW): FSM→IDLE; the pending write is discarded and the RAM is not written.
- Reset values: hreadyout=1, hresp=0, hrdata=0, ram_we=0, ram_addr=0, ram_wdata=0.

## Timing
- Read: 1 wait state, so the data phase is 2 cycles.
- Word write: 0 wait states. The RAM is written at the end of the data-phase cycle.
- Sub-word write: 1 wait state. The RAM is read in cycle 1 and written in cycle 2.
- ERROR: a 2-cycle response, per AHB-Lite.
- Write then read to the same address, back-to-back: the write commits at the end of WR, and the RD cycle follows, so the read returns the new data. No forwarding logic is needed.
- RAM outputs are combinational from the FSM state and latched registers. hwdata is used combinationally only in WR.
- The port is used exactly once per data-phase cycle, so there are no port conflicts.

## Configuration
- Macro: SOC_RAM_CTRL_RMW_EN.
- Defined: sub-word writes use RMW_RD/RMW_WR as described above.
- Undefined: RMW states and wdata_q are removed. Byte and half writes are treated as illegal and get an ERROR response (ERR1/ERR2). Sub-word reads are unaffected.

## Structure
- Package soc_ram_ctrl_pkg holds:
  - FSM state encoding (3 bits);
  - HTRANS constants (IDLE, BUSY, NONSEQ, SEQ);
  - HSIZE constants (BYTE, HALF, WORD);
  - HRESP constants (OKAY, ERROR).
- One combinational sub-module, soc_ram_byte_merge. Inputs: old word, new word, size, addr[1:0]. Output: merged word. It is instantiated only under SOC_RAM_CTRL_RMW_EN.

## Test plan
- Word write 0xDEADBEEF to 0x10, then read 0x10: write has hreadyout=1 with no wait; read has one cycle of hreadyout=0, then hrdata=0xDEADBEEF.
- With 0x11223344 at 0x20, byte write 0xAA at 0x22 (hwdata=0x00AA0000): one wait state; a following read returns 0x11AA3344.
- Half write 0xBEEF at 0x26 over 0x11223344: readback is 0xBEEF3344. Half write at 0x25: ERROR for two cycles (hresp=1, hreadyout 0 then 1), and the RAM is unchanged.
- Back-to-back pipelined word write at 0x30 followed immediately by a read of 0x30: the read returns the new value, with no stall beyond the single read wait state.
- Assert pad_cpu_rst_b low during RMW_RD of a byte write to 0x40: all outputs take reset values, and the RAM word at 0x40 is unchanged after reset is released.
- Build without SOC_RAM_CTRL_RMW_EN: a byte write gets ERROR; a byte read of 0x20 returns the full word 0x11223344 with OKAY.
